model_matrix_vector_streamer: RTL and testbench

Upstream feeder for `model_matrix_vector_product`. It holds one matrix A (up to 2^INDEX_SIZE × 2^INDEX_SIZE) and one vector B (up to 2^INDEX_SIZE) loaded through a simple write port. On START it replays them as a row-major element stream with the I/J/B enable strobes the product stage consumes. A PAUSE input gives downstream backpressure.

---
 rtl/model_matrix_vector_pkg.sv | 19 +
 rtl/model_index_counter_2d.sv | 39 +++
 rtl/model_matrix_vector_streamer.sv | 156 +++++++++++++++
 tb/tb_model_matrix_vector_streamer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/model_matrix_vector_pkg.sv
// Shared definitions for the matrix/vector streaming stages:
// FSM state encoding, data/control constants and write-select codes.
package model_matrix_vector_pkg;

  typedef enum logic [1:0] {
    IDLE_STATE   = 2'd0,
    STREAM_STATE = 2'd1,
    DONE_STATE   = 2'd2
  } state_t;

  localparam int   ZERO_DATA    = 0;
  localparam int   ONE_DATA     = 1;
  localparam logic ZERO_CONTROL = 1'b0;
  localparam logic ONE_CONTROL  = 1'b1;

  localparam logic WR_SEL_MATRIX = 1'b0;
  localparam logic WR_SEL_VECTOR = 1'b1;

endpackage

// File: rtl/model_index_counter_2d.sv
// Row-major i/j position counter. j wraps at limit_j and carries into i;
// limits are "size minus one". enable freezes the position when low.
module model_index_counter_2d #(
  parameter int INDEX_SIZE = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [INDEX_SIZE-1:0] limit_i,
  input  logic [INDEX_SIZE-1:0] limit_j,
  output logic [INDEX_SIZE-1:0] index_i,
  output logic [INDEX_SIZE-1:0] index_j,
  output logic                  first_of_row,
  output logic                  last_element
);

  // position register: clear wins over enable
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      index_i <= '0;
      index_j <= '0;
    end else if (clear) begin
      index_i <= '0;
      index_j <= '0;
    end else if (enable) begin
      if (index_j == limit_j) begin
        index_j <= '0;
        index_i <= (index_i == limit_i) ? '0 : index_i + INDEX_SIZE'(1);
      end else begin
        index_j <= index_j + INDEX_SIZE'(1);
      end
    end
  end

  assign first_of_row = (index_j == '0);
  assign last_element = (index_i == limit_i) && (index_j == limit_j);

endmodule

// File: rtl/model_matrix_vector_streamer.sv
// Holds matrix A and vector B, replays them row-major on START with the
// I/J/B strobes of the product stage. PAUSE stalls the stream in place.
// Optional START size checking: MODEL_MATRIX_VECTOR_STREAMER_BOUNDS_CHECK_EN.
//
// state        | meaning
// IDLE_STATE   | storage writable, waiting for START
// STREAM_STATE | one element per non-paused cycle
// DONE_STATE   | stream finished or rejected, READY follows
module model_matrix_vector_streamer
  import model_matrix_vector_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4,
  parameter int INDEX_SIZE   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  READY,
  output logic                  ERROR,
  input  logic                  PAUSE,
  input  logic                  WR_ENABLE,
  input  logic                  WR_SEL,
  input  logic [INDEX_SIZE-1:0] WR_I,
  input  logic [INDEX_SIZE-1:0] WR_J,
  input  logic [DATA_SIZE-1:0]  WR_DATA,
  input  logic [DATA_SIZE-1:0]  SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]  SIZE_J_IN,
  output logic [DATA_SIZE-1:0]  DATA_A_OUT,
  output logic [DATA_SIZE-1:0]  DATA_B_OUT,
  output logic                  DATA_A_OUT_I_ENABLE,
  output logic                  DATA_A_OUT_J_ENABLE,
  output logic                  DATA_B_OUT_ENABLE
);

  localparam int CAP = 1 << INDEX_SIZE;
  localparam int unused_control_size = CONTROL_SIZE;

  state_t state, next_state;

  logic [DATA_SIZE-1:0]  mem_a [CAP*CAP];
  logic [DATA_SIZE-1:0]  mem_b [CAP];
  logic [INDEX_SIZE-1:0] lim_i, lim_j, start_lim_i, start_lim_j;
  logic [INDEX_SIZE-1:0] idx_i, idx_j;
  logic                  first_of_row, last_element;
  logic                  start_acc, advance, reject;

  assign start_acc = (state == IDLE_STATE) && START;
  assign advance   = (state == STREAM_STATE) && !PAUSE;

  // low bits of SIZE-1: wraps a size of 0 to full capacity
  assign start_lim_i = SIZE_I_IN[INDEX_SIZE-1:0] - INDEX_SIZE'(1);
  assign start_lim_j = SIZE_J_IN[INDEX_SIZE-1:0] - INDEX_SIZE'(1);

`ifdef MODEL_MATRIX_VECTOR_STREAMER_BOUNDS_CHECK_EN
  logic err_q;

  assign reject = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) ||
                  (SIZE_I_IN > DATA_SIZE'(CAP)) || (SIZE_J_IN > DATA_SIZE'(CAP));

  // remember whether the accepted START was rejected; ERROR goes out with READY
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= ZERO_CONTROL;
      ERROR <= ZERO_CONTROL;
    end else begin
      if (start_acc) err_q <= reject;
      ERROR <= (state == DONE_STATE) && err_q;
    end
  end
`else
  logic unused_size_bits;

  assign reject = ZERO_CONTROL;
  assign ERROR  = ZERO_CONTROL;
  assign unused_size_bits = ^{SIZE_I_IN[DATA_SIZE-1:INDEX_SIZE],
                              SIZE_J_IN[DATA_SIZE-1:INDEX_SIZE]};
`endif

  // storage is deliberately not reset so contents survive RST
  always_ff @(posedge CLK) begin
    if ((state == IDLE_STATE) && WR_ENABLE) begin
      if (WR_SEL == WR_SEL_MATRIX) mem_a[{WR_I, WR_J}] <= WR_DATA;
      else                         mem_b[WR_J]         <= WR_DATA;
    end
  end

  // stream dimensions latched at an accepted START
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lim_i <= '0;
      lim_j <= '0;
    end else if (start_acc) begin
      lim_i <= start_lim_i;
      lim_j <= start_lim_j;
    end
  end

  model_index_counter_2d #(
    .INDEX_SIZE (INDEX_SIZE)
  ) u_index_counter (
    .CLK          (CLK),
    .RST          (RST),
    .clear        (start_acc),
    .enable       (advance),
    .limit_i      (lim_i),
    .limit_j      (lim_j),
    .index_i      (idx_i),
    .index_j      (idx_j),
    .first_of_row (first_of_row),
    .last_element (last_element)
  );

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE_STATE;
    else      state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE_STATE:   if (START) next_state = reject ? DONE_STATE : STREAM_STATE;
      STREAM_STATE: if (advance && last_element) next_state = DONE_STATE;
      DONE_STATE:   next_state = IDLE_STATE;
      default:      next_state = IDLE_STATE;
    endcase
  end

  // registered outputs: data holds whenever no element is emitted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      READY               <= ZERO_CONTROL;
      DATA_A_OUT          <= DATA_SIZE'(ZERO_DATA);
      DATA_B_OUT          <= DATA_SIZE'(ZERO_DATA);
      DATA_A_OUT_I_ENABLE <= ZERO_CONTROL;
      DATA_A_OUT_J_ENABLE <= ZERO_CONTROL;
      DATA_B_OUT_ENABLE   <= ZERO_CONTROL;
    end else begin
      READY <= (state == DONE_STATE);
      if (advance) begin
        DATA_A_OUT          <= mem_a[{idx_i, idx_j}];
        DATA_B_OUT          <= mem_b[idx_j];
        DATA_A_OUT_I_ENABLE <= first_of_row;
        DATA_A_OUT_J_ENABLE <= ONE_CONTROL;
        DATA_B_OUT_ENABLE   <= ONE_CONTROL;
      end else begin
        DATA_A_OUT_I_ENABLE <= ZERO_CONTROL;
        DATA_A_OUT_J_ENABLE <= ZERO_CONTROL;
        DATA_B_OUT_ENABLE   <= ZERO_CONTROL;
      end
    end
  end

endmodule

// File: tb/tb_model_matrix_vector_streamer.sv
// Self-checking bench for model_matrix_vector_streamer (INDEX_SIZE=2).
// Reference: plain arrays for A/B and a row-major element index.
module tb_model_matrix_vector_streamer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0, PAUSE = 1'b0;
  logic        WR_ENABLE = 1'b0, WR_SEL = 1'b0;
  logic [1:0]  WR_I = '0, WR_J = '0;
  logic [63:0] WR_DATA = '0, SIZE_I_IN = '0, SIZE_J_IN = '0;
  logic        READY, ERROR;
  logic [63:0] DATA_A_OUT, DATA_B_OUT;
  logic        DATA_A_OUT_I_ENABLE, DATA_A_OUT_J_ENABLE, DATA_B_OUT_ENABLE;

  int checks = 0;
  int errors = 0;

  logic [63:0] ref_a [4][4];
  logic [63:0] ref_b [4];
  logic [63:0] last_a = '0, last_b = '0;

  model_matrix_vector_streamer #(
    .DATA_SIZE (64), .CONTROL_SIZE (4), .INDEX_SIZE (2)
  ) dut (
    .CLK (CLK), .RST (RST), .START (START), .READY (READY), .ERROR (ERROR),
    .PAUSE (PAUSE), .WR_ENABLE (WR_ENABLE), .WR_SEL (WR_SEL), .WR_I (WR_I),
    .WR_J (WR_J), .WR_DATA (WR_DATA), .SIZE_I_IN (SIZE_I_IN), .SIZE_J_IN (SIZE_J_IN),
    .DATA_A_OUT (DATA_A_OUT), .DATA_B_OUT (DATA_B_OUT),
    .DATA_A_OUT_I_ENABLE (DATA_A_OUT_I_ENABLE),
    .DATA_A_OUT_J_ENABLE (DATA_A_OUT_J_ENABLE),
    .DATA_B_OUT_ENABLE (DATA_B_OUT_ENABLE)
  );

  always #5 CLK = ~CLK;

  function automatic int eff_size(input int s);
    return (s == 0) ? 4 : ((s - 1) % 4) + 1;
  endfunction

  task automatic write_elem(input bit sel, input int i, input int j, input logic [63:0] d);
    @(negedge CLK);
    WR_ENABLE = 1'b1; WR_SEL = sel; WR_I = 2'(i); WR_J = 2'(j); WR_DATA = d;
    @(posedge CLK); #1;
    WR_ENABLE = 1'b0;
    if (sel) ref_b[j] = d;
    else     ref_a[i][j] = d;
  endtask

  // directed: A[i][j]=10i+j, B[j]=j+1; otherwise random contents
  task automatic load_all(input bit directed);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        write_elem(1'b0, i, j, directed ? 64'(10 * i + j) : {$urandom, $urandom});
    for (int j = 0; j < 4; j++)
      write_elem(1'b1, 0, j, directed ? 64'(j + 1) : {$urandom, $urandom});
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({READY, ERROR, DATA_A_OUT_I_ENABLE, DATA_A_OUT_J_ENABLE, DATA_B_OUT_ENABLE} !== 5'b0 ||
        DATA_A_OUT !== 64'd0 || DATA_B_OUT !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b a=%h b=%h required all zero",
               {READY, ERROR, DATA_A_OUT_I_ENABLE, DATA_A_OUT_J_ENABLE, DATA_B_OUT_ENABLE},
               DATA_A_OUT, DATA_B_OUT);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // pause_mode: 0 none, 1 stall the 3rd and 4th stream cycles, 2 random
  // disturb: hold WR_ENABLE and START high throughout the stream
  task automatic test_stream(input string name, input int size_i, input int size_j,
                             input int pause_mode, input bit disturb);
    int si, sj, total, emitted, npause, ready_cycle;
    bit p, done;
    logic [63:0] ea, eb;
    logic [2:0]  een;
    si = eff_size(size_i); sj = eff_size(size_j); total = si * sj;
    emitted = 0; npause = 0; done = 0; ready_cycle = 0;
    @(negedge CLK);
    START = 1'b1; SIZE_I_IN = 64'(size_i); SIZE_J_IN = 64'(size_j); PAUSE = 1'b0;
    @(posedge CLK); #1;
    if (!disturb) START = 1'b0;
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge CLK);
      p = 0;
      if (emitted < total) begin
        if (pause_mode == 1) p = (k == 3 || k == 4);
        else if (pause_mode == 2) p = ($urandom_range(0, 3) == 0);
      end
      PAUSE = p;
      if (disturb) begin
        WR_ENABLE = 1'b1; WR_SEL = 1'($urandom); WR_I = 2'($urandom); WR_J = 2'($urandom);
        WR_DATA = {$urandom, $urandom}; START = 1'b1;
      end
      @(posedge CLK); #1;
      if (emitted < total) begin
        if (p) begin
          npause++;
          een = 3'b000;
        end else begin
          last_a = ref_a[emitted / sj][emitted % sj];
          last_b = ref_b[emitted % sj];
          een = {(emitted % sj) == 0, 2'b11};
          emitted++;
        end
        checks++;
        if (READY !== 1'b0) begin
          errors++;
          $display("FAIL %s early_ready: cycle %0d READY=%b required 0", name, k, READY);
        end
      end else begin
        een = 3'b000;
        done = 1;
        ready_cycle = k;
        checks++;
        if (READY !== 1'b1) begin
          errors++;
          $display("FAIL %s ready: cycle %0d READY=%b required 1", name, k, READY);
        end
        checks++;
        if (k != total + npause + 1) begin
          errors++;
          $display("FAIL %s ready_latency: cycle %0d required %0d", name, k, total + npause + 1);
        end
      end
      ea = last_a; eb = last_b;
      checks++;
      if ({DATA_A_OUT_I_ENABLE, DATA_A_OUT_J_ENABLE, DATA_B_OUT_ENABLE} !== een || ERROR !== 1'b0) begin
        errors++;
        $display("FAIL %s enables: cycle %0d ien/jen/ben=%b err=%b required %b err=0", name, k,
                 {DATA_A_OUT_I_ENABLE, DATA_A_OUT_J_ENABLE, DATA_B_OUT_ENABLE}, ERROR, een);
      end
      checks++;
      if (DATA_A_OUT !== ea || DATA_B_OUT !== eb) begin
        errors++;
        $display("FAIL %s data: cycle %0d a=%h b=%h required a=%h b=%h", name, k,
                 DATA_A_OUT, DATA_B_OUT, ea, eb);
      end
    end
    START = 1'b0; WR_ENABLE = 1'b0; PAUSE = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: no READY within bound, ready_cycle=%0d", name, ready_cycle);
    end
    @(posedge CLK); #1;
    checks++;
    if (READY !== 1'b0) begin
      errors++;
      $display("FAIL %s single_ready: READY=%b one cycle after pulse, required 0", name, READY);
    end
  endtask

  task automatic test_reset_mid;
    int ready_seen;
    ready_seen = 0;
    load_all(1'b0);
    @(negedge CLK);
    START = 1'b1; SIZE_I_IN = 64'd4; SIZE_J_IN = 64'd4;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    last_a = '0; last_b = '0;
    checks++;
    if ({READY, ERROR, DATA_A_OUT_I_ENABLE, DATA_A_OUT_J_ENABLE, DATA_B_OUT_ENABLE} !== 5'b0 ||
        DATA_A_OUT !== 64'd0 || DATA_B_OUT !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: ctl=%b a=%h b=%h required all zero",
               {READY, ERROR, DATA_A_OUT_I_ENABLE, DATA_A_OUT_J_ENABLE, DATA_B_OUT_ENABLE},
               DATA_A_OUT, DATA_B_OUT);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      if (READY !== 1'b0 || DATA_A_OUT_J_ENABLE !== 1'b0) ready_seen++;
    end
    checks++;
    if (ready_seen != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d cycles with READY/enable after abort, required 0", ready_seen);
    end
    test_stream("reset_restart", 4, 4, 0, 1'b0);
  endtask

`ifdef MODEL_MATRIX_VECTOR_STREAMER_BOUNDS_CHECK_EN
  task automatic test_bounds;
    int szi [2] = '{0, 2};
    int szj [2] = '{3, 5};
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      START = 1'b1; SIZE_I_IN = 64'(szi[c]); SIZE_J_IN = 64'(szj[c]);
      @(posedge CLK); #1;
      START = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if ({READY, ERROR, DATA_A_OUT_I_ENABLE, DATA_A_OUT_J_ENABLE, DATA_B_OUT_ENABLE} !== 5'b11000 ||
          DATA_A_OUT !== last_a || DATA_B_OUT !== last_b) begin
        errors++;
        $display("FAIL bounds_reject%0d: rdy/err/en=%b a=%h required 11000 a=%h", c,
                 {READY, ERROR, DATA_A_OUT_I_ENABLE, DATA_A_OUT_J_ENABLE, DATA_B_OUT_ENABLE},
                 DATA_A_OUT, last_a);
      end
      @(posedge CLK); #1;
      checks++;
      if ({READY, ERROR} !== 2'b00) begin
        errors++;
        $display("FAIL bounds_after%0d: rdy/err=%b required 00", c, {READY, ERROR});
      end
    end
  endtask
`endif

  task automatic test_random;
    int si, sj, lo, hi;
`ifdef MODEL_MATRIX_VECTOR_STREAMER_BOUNDS_CHECK_EN
    lo = 1; hi = 4;
`else
    lo = 0; hi = 9;
`endif
    for (int n = 0; n < 6; n++) begin
      load_all(1'b0);
      si = $urandom_range(hi, lo);
      sj = $urandom_range(hi, lo);
      test_stream("random", si, sj, 2, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    load_all(1'b1);
    test_stream("basic_2x3", 2, 3, 0, 1'b0);
    test_stream("pause_2x3", 2, 3, 1, 1'b0);
    test_reset_mid;
    test_stream("disturb", 3, 4, 2, 1'b1);
    test_stream("after_disturb", 4, 4, 0, 1'b0);
`ifdef MODEL_MATRIX_VECTOR_STREAMER_BOUNDS_CHECK_EN
    test_bounds;
`else
    test_stream("size_zero_wrap", 0, 1, 0, 1'b0);
`endif
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
